matrix_inverse_reader: RTL and testbench

// - Read-out end of the 5x5 Gauss-Jordan inverter. Walks its 5x10 fraction-free augmented array [D|N].
// - Divides each right-half element N[r][c] by its row pivot D[r][r].
// - Streams the 25 inverse elements out as signed fixed-point on a valid/ready interface.
// - Sits between the inverter's storage read port and any downstream consumer (UART/debug/verify).

---
 rtl/matrix_pkg.sv | 59 +++++
 rtl/matrix_inverse_reader_if.sv | 29 ++
 rtl/seq_signed_divider.sv | 103 ++++++++++
 rtl/matrix_inverse_reader.sv | 147 ++++++++++++++
 tb/tb_matrix_inverse_reader.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// Shared types, constants and arithmetic helpers for the matrix read-out and normalising blocks.
// Elements are signed; results are signed Q(DATA_W-FRAC_BITS).FRAC_BITS.
package matrix_pkg;

   localparam int N_DIM      = 5;
   localparam int DATA_W     = 32;
   localparam int FRAC_BITS  = 16;
   localparam int ROW_STRIDE = 2 * N_DIM;
   localparam int ADDR_W     = 6;
   localparam int IDX_W      = 3;
   localparam int QUO_W      = DATA_W + FRAC_BITS;
   localparam int CNT_W      = $clog2(QUO_W + 1);

   localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(N_DIM - 1);
   localparam logic signed [DATA_W-1:0] Q_MAX    = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] Q_MIN    = {1'b1, {(DATA_W-1){1'b0}}};

   typedef enum logic [3:0] {
      S_IDLE,
      S_RD_PIV,
      S_WAIT_PIV,
      S_RD_EL,
      S_WAIT_EL,
      S_DIV,
      S_OUT,
      S_FIN,
      S_ERR_END
   } state_t;

   typedef struct packed {
      logic signed [DATA_W-1:0] data;
      logic                     sat;
   } q_result_t;

   // One extra bit so the most-negative element has a representable magnitude.
   function automatic logic [DATA_W:0] mag_of(input logic signed [DATA_W-1:0] v);
      logic signed [DATA_W:0] ext;
      ext = {v[DATA_W-1], v};
      return v[DATA_W-1] ? $unsigned(-ext) : $unsigned(ext);
   endfunction

   function automatic q_result_t saturate_q(input logic [QUO_W-1:0] mag, input logic neg);
      q_result_t r;
      r = '0;
      if (mag > {{(QUO_W-DATA_W){1'b0}}, Q_MAX}) begin
         r.sat  = 1'b1;
         r.data = neg ? Q_MIN : Q_MAX;
      end else begin
         r.data = neg ? -$signed(mag[DATA_W-1:0]) : $signed(mag[DATA_W-1:0]);
      end
      return r;
   endfunction

   function automatic logic [ADDR_W-1:0] elem_addr(input logic [IDX_W-1:0]  row,
                                                    input logic [ADDR_W-1:0] col);
      return ADDR_W'(row) * ADDR_W'(ROW_STRIDE) + col;
   endfunction

endpackage

// File: rtl/matrix_inverse_reader_if.sv
// Storage read port plus the inverse-element output stream of the matrix read-out block.
interface matrix_inverse_reader_if;
   import matrix_pkg::*;

   logic [ADDR_W-1:0] rd_addr;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;

   logic              out_valid;
   logic              out_ready;
   logic [IDX_W-1:0]  out_row;
   logic [IDX_W-1:0]  out_col;
   logic [DATA_W-1:0] out_data;

   modport master (
      output rd_addr, rd_en,
      input  rd_data,
      output out_valid, out_row, out_col, out_data,
      input  out_ready
   );

   modport slave (
      input  rd_addr, rd_en,
      output rd_data,
      input  out_valid, out_row, out_col, out_data,
      output out_ready
   );

endinterface

// File: rtl/seq_signed_divider.sv
// Sequential signed divider: (|num| << FRAC_BITS) / |den| by restoring division, one quotient
// bit per cycle, sign applied afterwards and the result saturated to signed Q format.
module seq_signed_divider
   import matrix_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start_i,
   input  logic signed [DATA_W-1:0] dividend_i,
   input  logic signed [DATA_W-1:0] divisor_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic signed [DATA_W-1:0] quot_o,
   output logic                     sat_o
);

   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic                     neg_q, neg_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [DATA_W-1:0]        rem_q, rem_d;
   logic [DATA_W:0]          dvs_q, dvs_d;
   logic [QUO_W-1:0]         quo_q, quo_d;
   logic signed [DATA_W-1:0] res_q, res_d;
   logic                     sat_q, sat_d;

   logic [DATA_W:0]          rem_shift;
   logic [DATA_W:0]          trial;
   q_result_t                fin;

   always_comb begin
      // NOTE: every variable written here gets a default first; a path that skips an assignment would infer a latch.
      busy_d    = busy_q;
      done_d    = 1'b0;
      neg_d     = neg_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      quo_d     = quo_q;
      res_d     = res_q;
      sat_d     = sat_q;
      fin       = '0;
      rem_shift = {rem_q, quo_q[QUO_W-1]};
      trial     = rem_shift - dvs_q;

      if (start_i && !busy_q) begin
         busy_d = 1'b1;
         neg_d  = dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1];
         cnt_d  = CNT_W'(QUO_W);
         rem_d  = '0;
         dvs_d  = mag_of(divisor_i);
         quo_d  = QUO_W'({mag_of(dividend_i), {FRAC_BITS{1'b0}}});
      end else if (busy_q) begin
         // The dividend shifts out of quo_q from the top while quotient bits enter at the bottom.
         if (rem_shift >= dvs_q) begin
            rem_d = DATA_W'(trial);
            quo_d = {quo_q[QUO_W-2:0], 1'b1};
         end else begin
            rem_d = DATA_W'(rem_shift);
            quo_d = {quo_q[QUO_W-2:0], 1'b0};
         end
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CNT_W'(1)) begin
            fin    = saturate_q(quo_d, neg_q);
            busy_d = 1'b0;
            done_d = 1'b1;
            res_d  = fin.data;
            sat_d  = fin.sat;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
         neg_q  <= 1'b0;
         cnt_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
         quo_q  <= '0;
         res_q  <= '0;
         sat_q  <= 1'b0;
      end else begin
         busy_q <= busy_d;
         done_q <= done_d;
         neg_q  <= neg_d;
         cnt_q  <= cnt_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
         quo_q  <= quo_d;
         res_q  <= res_d;
         sat_q  <= sat_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign quot_o = res_q;
   assign sat_o  = sat_q;

endmodule

// File: rtl/matrix_inverse_reader.sv
// Read-out end of the Gauss-Jordan inverter: walks the [D|N] array row by row and streams
// N[r][c]/D[r][r] as signed Q16.16 on a valid/ready stream.
module matrix_inverse_reader
   import matrix_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start_i,
   input  logic                    e_flag_i,
   matrix_inverse_reader_if.master bus,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    err_o,
   output logic                    sat_o
);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  row_q, row_d;
   logic [IDX_W-1:0]  col_q, col_d;
   logic [DATA_W-1:0] piv_q, piv_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;
   logic              sat_q, sat_d;

   logic              div_start;
   logic              div_busy;
   logic              div_done;
   logic [DATA_W-1:0] div_quot;
   logic              div_sat;

   seq_signed_divider u_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (div_start),
      .dividend_i (bus.rd_data),
      .divisor_i  (piv_q),
      .busy_o     (div_busy),
      .done_o     (div_done),
      .quot_o     (div_quot),
      .sat_o      (div_sat)
   );

   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      col_d     = col_q;
      piv_d     = piv_q;
      data_d    = data_q;
      valid_d   = valid_q;
      err_d     = err_q;
      sat_d     = sat_q;
      div_start = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               row_d   = '0;
               col_d   = '0;
               sat_d   = 1'b0;
               err_d   = e_flag_i;
               state_d = e_flag_i ? S_ERR_END : S_RD_PIV;
            end
         end
         S_RD_PIV:   state_d = S_WAIT_PIV;
         S_WAIT_PIV: begin
            piv_d = bus.rd_data;
            if (bus.rd_data == '0) begin
               err_d   = 1'b1;
               state_d = S_ERR_END;
            end else begin
               state_d = S_RD_EL;
            end
         end
         S_RD_EL:    state_d = S_WAIT_EL;
         S_WAIT_EL: begin
            div_start = 1'b1;
            state_d   = S_DIV;
         end
         S_DIV: begin
            if (div_done) begin
               data_d  = div_quot;
               sat_d   = sat_q | div_sat;
               valid_d = 1'b1;
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            // Column advances before row; the pivot is re-read only when a new row starts.
            if (bus.out_ready) begin
               valid_d = 1'b0;
               if (col_q != LAST_IDX) begin
                  col_d   = col_q + 1'b1;
                  state_d = S_RD_EL;
               end else if (row_q != LAST_IDX) begin
                  row_d   = row_q + 1'b1;
                  col_d   = '0;
                  state_d = S_RD_PIV;
               end else begin
                  state_d = S_FIN;
               end
            end
         end
         S_FIN, S_ERR_END: state_d = S_IDLE;
         default:          state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         row_q   <= '0;
         col_q   <= '0;
         piv_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         piv_q   <= piv_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         sat_q   <= sat_d;
      end
   end

   assign bus.rd_en   = (state_q == S_RD_PIV) || (state_q == S_RD_EL);
   assign bus.rd_addr = (state_q == S_RD_PIV) ? elem_addr(row_q, ADDR_W'(row_q)) :
                        (state_q == S_RD_EL)  ? elem_addr(row_q, ADDR_W'(N_DIM) + ADDR_W'(col_q)) :
                                                '0;

   // Every output is a flop or a decode of flops, so out_ready never reaches out_valid.
   assign bus.out_valid = valid_q;
   assign bus.out_row   = row_q;
   assign bus.out_col   = col_q;
   assign bus.out_data  = data_q;

   assign busy_o = div_busy || !(state_q inside {S_IDLE, S_FIN, S_ERR_END});
   assign done_o = (state_q == S_FIN) || (state_q == S_ERR_END);
   assign err_o  = err_q;
   assign sat_o  = sat_q;

endmodule

// File: tb/tb_matrix_inverse_reader.sv
// Randomised bench for matrix_inverse_reader: a behavioural array/division model builds the
// expected beat list and one monitor compares every accepted beat and every held beat.
module tb_matrix_inverse_reader;
   import matrix_pkg::*;

   typedef struct {
      int          row;
      int          col;
      logic [31:0] data;
   } beat_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic e_flag = 1'b0;
   logic busy, done, err, sat;

   matrix_inverse_reader_if bus ();

   matrix_inverse_reader dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start_i  (start),
      .e_flag_i (e_flag),
      .bus      (bus),
      .busy_o   (busy),
      .done_o   (done),
      .err_o    (err),
      .sat_o    (sat)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:49];
   always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
   endtask

   // Reference: exact integer quotient truncated toward zero, then clamped.
   function automatic void ref_div(input logic [31:0] n, input logic [31:0] d,
                                   output logic [31:0] q, output bit s);
      longint num, den, quo;
      num = longint'($signed(n)) * (longint'(1) << FRAC_BITS);
      den = longint'($signed(d));
      quo = num / den;
      s   = (quo > 2147483647) || (quo < -2147483647);
      if (quo > 2147483647)       q = 32'h7FFF_FFFF;
      else if (quo < -2147483647) q = 32'h8000_0000;
      else                        q = quo[31:0];
   endfunction

   beat_t       exp_q[$];
   beat_t       e;
   int          exp_n, beats, done_cnt, rd_cnt;
   bit          exp_err, exp_sat;
   logic [31:0] got [0:4][0:4];

   task automatic build_expected();
      logic [31:0] q;
      bit          s;
      exp_q.delete();
      exp_err = 1'b0;
      exp_sat = 1'b0;
      for (int r = 0; r < N_DIM; r++)
         for (int c = 0; c < N_DIM; c++) got[r][c] = 32'hDEAD_BEEF;
      for (int r = 0; r < N_DIM; r++) begin
         if (mem[r*ROW_STRIDE + r] == 32'h0) begin
            exp_err = 1'b1;
            break;
         end
         for (int c = 0; c < N_DIM; c++) begin
            ref_div(mem[r*ROW_STRIDE + N_DIM + c], mem[r*ROW_STRIDE + r], q, s);
            exp_q.push_back('{r, c, q});
            exp_sat |= s;
         end
      end
      exp_n    = exp_q.size();
      beats    = 0;
      done_cnt = 0;
      rd_cnt   = 0;
   endtask

   always @(negedge clk) begin
      if (done)       done_cnt++;
      if (bus.rd_en)  rd_cnt++;
   end

   bit               ready_rand = 1'b0;
   bit               stall_req  = 1'b0;

   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (stall_req && bus.out_valid) begin
            stall_req     = 1'b0;
            bus.out_ready = 1'b0;
            repeat (10) @(posedge clk);
         end else begin
            bus.out_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
      end
   end

   bit              hold_pend = 1'b0;
   logic [IDX_W-1:0] h_row, h_col;
   logic [31:0]      h_data;

   always @(negedge clk) begin
      if (!rst_n) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend)
            check("hold_stable", {bus.out_valid, bus.out_row, bus.out_col, bus.out_data},
                  {1'b1, h_row, h_col, h_data});
         hold_pend = 1'b0;
         if (bus.out_valid && bus.out_ready) begin
            beats++;
            if (exp_q.size() == 0) begin
               check("unexpected_beat", beats, exp_n);
            end else begin
               e = exp_q.pop_front();
               check("beat_index", {bus.out_row, bus.out_col}, {e.row[2:0], e.col[2:0]});
               check("beat_data", bus.out_data, e.data);
               got[e.row][e.col] = bus.out_data;
            end
         end else if (bus.out_valid) begin
            hold_pend = 1'b1;
            h_row     = bus.out_row;
            h_col     = bus.out_col;
            h_data    = bus.out_data;
         end
      end
   end

   task automatic set_identity();
      for (int r = 0; r < N_DIM; r++)
         for (int c = 0; c < N_DIM; c++) begin
            mem[r*ROW_STRIDE + c]         = (r == c) ? 32'h1 : 32'h0;
            mem[r*ROW_STRIDE + N_DIM + c] = (r == c) ? 32'h1 : 32'h0;
         end
   endtask

   task automatic set_random();
      logic [31:0] v;
      for (int i = 0; i < 50; i++) begin
         v = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 1) == 1) v = -v;
         mem[i] = v;
      end
      for (int r = 0; r < N_DIM; r++)
         if (mem[r*ROW_STRIDE + r] == 32'h0) mem[r*ROW_STRIDE + r] = 32'h1;
   endtask

   task automatic run_stream(input string tag, input bit mid_start);
      build_expected();
      @(posedge clk);
      #1 start = 1'b1;
      e_flag   = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < 5000 && done_cnt == 0; i++) begin
         @(negedge clk);
         if (mid_start) begin
            start  = (i == 100);
            e_flag = (i == 100);
         end
      end
      start  = 1'b0;
      e_flag = 1'b0;
      repeat (3) @(negedge clk);
      check({tag, "_done_count"}, done_cnt, 1);
      check({tag, "_beat_count"}, beats, exp_n);
      check({tag, "_beats_left"}, exp_q.size(), 0);
      check({tag, "_err"}, err, exp_err);
      check({tag, "_sat"}, sat, exp_sat);
      check({tag, "_busy_after"}, busy, 1'b0);
   endtask

   initial begin
      logic [31:0] q;
      bit          s;

      ref_div(32'h2, 32'h4, q, s);
      check("model_half", {s, q}, {1'b0, 32'h0000_8000});
      ref_div(32'h1, 32'hFFFF_FFFD, q, s);
      check("model_neg_third", {s, q}, {1'b0, 32'hFFFF_AAAB});
      ref_div(32'h0001_0000, 32'h1, q, s);
      check("model_sat_pos", {s, q}, {1'b1, 32'h7FFF_FFFF});
      ref_div(32'hFFFF_0000, 32'h1, q, s);
      check("model_sat_neg", {s, q}, {1'b1, 32'h8000_0000});
      ref_div(32'h8000_0000, 32'h8000_0000, q, s);
      check("model_most_neg", {s, q}, {1'b0, 32'h0001_0000});

      #12;
      check("reset_ctrl", {busy, done, err, sat, bus.out_valid, bus.rd_en}, 6'b0);
      check("reset_bus", {bus.rd_addr, bus.out_row, bus.out_col, bus.out_data}, '0);
      @(negedge clk);
      rst_n = 1'b1;

      set_identity();
      run_stream("identity", 1'b0);
      check("identity_diag", got[2][2], 32'h0001_0000);
      check("identity_off", got[2][3], 32'h0);

      set_random();
      mem[0]  = 32'h4;
      mem[5]  = 32'h2;
      mem[11] = 32'hFFFF_FFFD;
      mem[15] = 32'h1;
      mem[33] = 32'h8000_0000;
      mem[37] = 32'h8000_0000;
      ready_rand = 1'b1;
      run_stream("values", 1'b0);
      check("values_half", got[0][0], 32'h0000_8000);
      check("values_trunc", got[1][0], 32'hFFFF_AAAB);
      check("values_most_neg", got[3][2], 32'h0001_0000);

      set_random();
      ready_rand = 1'b0;
      stall_req  = 1'b1;
      run_stream("stall", 1'b1);
      check("stall_taken", stall_req, 1'b0);

      set_random();
      mem[22]    = 32'h0;
      ready_rand = 1'b1;
      run_stream("zero_pivot", 1'b0);
      check("zero_pivot_beats", beats, 10);

      set_identity();
      mem[0] = 32'h1;
      mem[5] = 32'h0001_0000;
      mem[6] = 32'hFFFF_0000;
      run_stream("saturate", 1'b0);
      check("saturate_pos", got[0][0], 32'h7FFF_FFFF);
      check("saturate_neg", got[0][1], 32'h8000_0000);

      exp_q.delete();
      exp_n    = 0;
      beats    = 0;
      done_cnt = 0;
      rd_cnt   = 0;
      @(posedge clk);
      #1 start = 1'b1;
      e_flag   = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      e_flag   = 1'b0;
      check("eflag_done", {done, err, busy}, 3'b110);
      @(posedge clk);
      #1 check("eflag_done_pulse", done, 1'b0);
      repeat (5) @(negedge clk);
      check("eflag_quiet", {rd_cnt[7:0], beats[7:0], done_cnt[7:0]}, {8'd0, 8'd0, 8'd1});

      build_expected();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int i = 0; i < 2000 && beats < 6; i++) @(negedge clk);
      check("rst_run_progress", beats >= 6, 1'b1);
      repeat (20) @(posedge clk);
      check("rst_sat_before", sat, 1'b1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("rst_async_drop", {busy, done, err, sat, bus.out_valid, bus.rd_en}, 6'b0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_no_done", done_cnt, 0);

      set_random();
      run_stream("fresh", 1'b0);
      for (int k = 0; k < 2; k++) begin
         set_random();
         ready_rand = (k == 0);
         run_stream("random", 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule
